pay_station: RTL and testbench
==============================

# pay_station

Exit-side payment terminal for the car park controller. On an exit request it computes the parking fee from the vehicle's entry timestamp and a free-running tick counter, collects coins, and issues the one-cycle `pay` pulse the park controller consumes to open the exit bar. It also returns change, or a full refund on cancel or timeout, and occupies the payment end of the Sout/Pay/Bout exit interface.

## Interface
- `TW`, 16: timestamp and tick-counter width.
- `TPU`, 60: clock ticks per billing unit, ≥1.
- `RATE`, 2: fee per started billing unit.
- `MAX_FEE`, 20: fee cap, ≥ RATE, < 2^CW.
- `CW`, 8: money width.
- `TIMEOUT`, 30000: idle cycles in collection before refund (used only with `PAY_TIMEOUT_EN`).

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: exit request, level or pulse; sampled only in IDLE.
- `entry_time` in TW: vehicle entry timestamp, sampled with `req`.
- `coin_valid` in 1: one coin this cycle.
- `coin_value` in CW: value of that coin.
- `cancel` in 1: abort payment.
- `busy` out 1: transaction in progress.
- `cost` out CW: computed fee, registered.
- `pay` out 1: one-cycle payment-complete pulse to the park controller.
- `refund` out 1: one-cycle aborted-transaction pulse.
- `change_valid` out 1: one-cycle strobe qualifying `change`.
- `change` out CW: change or refund amount.
- `now` out TW: free-running tick counter. Entry side samples it for timestamps.

## Operation
- `now` increments every cycle, wraps modulo 2^TW, and is 0 after reset.
- Elapsed time: `elapsed = now - entry_time` modulo 2^TW, latched when `req` is accepted.
- Fee formula: `fee = min(MAX_FEE, RATE * max(1, ceil(elapsed / TPU)))`. The minimum charge is one unit.
- States:
  - **IDLE**: if `req`, latch `elapsed`, clear `cost` and `paid`, and go to CALC.
  - **CALC**: one unit per cycle. Set `cost += RATE`, saturating at MAX_FEE. Set `remaining -= min(remaining, TPU)`. Go to COLLECT when `remaining` reaches 0 or `cost` reaches MAX_FEE after the update.
  - **COLLECT**: on `coin_valid`, set `paid += coin_value`, saturating at 2^CW-1. If `paid >= cost`, go to PAID. Otherwise, if `cancel` (or timeout), go to REFUND.
  - **PAID**: one cycle. Assert `pay` and `change_valid`, with `change = paid - cost`. Then go to IDLE.
  - **REFUND**: one cycle. Assert `refund` and `change_valid`, with `change = paid`. Then go to IDLE.
- `busy` is 1 in every state except IDLE.
- `req` outside IDLE is ignored. `coin_valid` outside COLLECT is ignored; the coin is not stored.
- Coin and `cancel` in the same cycle: the coin is added first. If it completes payment, PAID wins. Otherwise the transaction goes to REFUND, and the refund includes that coin.
- `cost` holds its value until the next accepted `req`. `change` holds until the next strobe.

## Timing
- Reset values: `busy`, `cost`, `pay`, `refund`, `change_valid`, `change`, and `now` are all 0. State is IDLE.
- `req` high at edge n: CALC is entered at n+1, and `busy` is 1 from n+1.
- CALC lasts k cycles, where k is the number of units charged, capped at MAX_FEE/RATE rounded up. `cost` is final on entry to COLLECT.
- A completing coin at edge m gives PAID at m+1: `pay`, `change_valid`, and `change` are valid for that single cycle. Back in IDLE at m+2.
- Cancel at edge m gives REFUND at m+1, IDLE at m+2.
- `rst` mid-transaction: immediate return to IDLE with reset values. No `pay` and no `refund` are issued, and collected money is discarded.

## Configuration
- `PAY_TIMEOUT_EN` defined:
  - A counter clears on COLLECT entry and on every accepted coin.
  - When it reaches TIMEOUT consecutive coinless COLLECT cycles, the next state is REFUND, exactly as for `cancel`.
- Not defined: no timeout counter. COLLECT waits indefinitely for payment or `cancel`.

## Test plan
- **Reset**: assert `rst` for 2 cycles, then release. All outputs are 0, `busy` stays 0 with no `req`, and `now` counts 0, 1, 2, …
- **Normal fee**: defaults, elapsed 150. CALC runs 3 cycles, `cost` = 6. Coins 5 then 5 give a single `pay` pulse with `change` = 4; `busy` drops the following cycle.
- **Cap and minimum**: elapsed 5000 gives `cost` = 20 after 10 CALC cycles. Elapsed 0 gives `cost` = 2.
- **Wrap-around**: `now` = 10, `entry_time` = 65530, so elapsed = 16 and `cost` = 2. An exact coin of 2 gives `pay` with `change` = 0.
- **Cancel and collision**: with `cost` = 6, coin 3 then `cancel` gives `refund` with `change` = 3 and no `pay`. A coin of 3 together with `cancel` at `paid` = 3 gives `pay` with `change` = 0 and no `refund`.
- **Timeout and reset** (with `PAY_TIMEOUT_EN`, TIMEOUT = 8): after coin 1, 8 idle cycles give `refund` with `change` = 1. Separately, `rst` asserted during COLLECT gives IDLE with no `pay` or `refund` pulse.

Source files
------------

// File: rtl/pay_station.sv
// rtl/pay_station.sv - exit payment terminal: fee calculation, coin collection, change and refund
// Optional collection timeout is enabled by defining PAY_TIMEOUT_EN.
module pay_station #(
    parameter int TW      = 16,
    parameter int TPU     = 60,
    parameter int RATE    = 2,
    parameter int MAX_FEE = 20,
    parameter int CW      = 8,
    parameter int TIMEOUT = 30000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [TW-1:0] entry_time,
    input  logic          coin_valid,
    input  logic [CW-1:0] coin_value,
    input  logic          cancel,
    output logic          busy,
    output logic [CW-1:0] cost,
    output logic          pay,
    output logic          refund,
    output logic          change_valid,
    output logic [CW-1:0] change,
    output logic [TW-1:0] now
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_COLLECT,
        S_PAID,
        S_REFUND
    } state_t;

    localparam logic [CW:0]   RATE_W    = (CW+1)'(RATE);
    localparam logic [CW:0]   MAX_FEE_W = (CW+1)'(MAX_FEE);
    localparam logic [TW-1:0] TPU_W     = TW'(TPU);

    if (TPU < 1 || RATE < 1 || MAX_FEE < RATE || MAX_FEE >= (1 << CW) || TIMEOUT < 1) begin : g_param_check
        $error("pay_station: invalid parameter set");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] now_q, now_d;
    logic [TW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] cost_q, cost_d;
    logic [CW-1:0] paid_q, paid_d;
    logic [CW-1:0] change_q, change_d;
    logic          busy_q, busy_d;
    logic          pay_q, pay_d;
    logic          refund_q, refund_d;
    logic          change_valid_q, change_valid_d;

    logic [CW:0]   cost_inc;
    logic [CW-1:0] cost_sat;
    logic [TW-1:0] rem_step;
    logic [TW-1:0] rem_next;
    logic [CW:0]   paid_sum;
    logic [CW-1:0] paid_new;
    logic          tmo_hit;

`ifdef PAY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts consecutive coinless COLLECT cycles; any other state or a coin clears it.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_COLLECT && !coin_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q == S_COLLECT) && !coin_valid && (tmo_q >= TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        cost_inc = {1'b0, cost_q} + RATE_W;
        cost_sat = (cost_inc > MAX_FEE_W) ? MAX_FEE_W[CW-1:0] : cost_inc[CW-1:0];
        rem_step = (remaining_q > TPU_W) ? TPU_W : remaining_q;
        rem_next = remaining_q - rem_step;
        paid_sum = {1'b0, paid_q} + {1'b0, coin_value};
        if (!coin_valid) begin
            paid_new = paid_q;
        end else if (paid_sum[CW]) begin
            paid_new = '1;
        end else begin
            paid_new = paid_sum[CW-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        now_d          = now_q + TW'(1);
        remaining_d    = remaining_q;
        cost_d         = cost_q;
        paid_d         = paid_q;
        change_d       = change_q;
        pay_d          = 1'b0;
        refund_d       = 1'b0;
        change_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    remaining_d = now_q - entry_time;
                    cost_d      = '0;
                    paid_d      = '0;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                // One billing unit per cycle; the first unit is always charged.
                cost_d      = cost_sat;
                remaining_d = rem_next;
                if (rem_next == '0 || cost_sat == MAX_FEE_W[CW-1:0]) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                paid_d = paid_new;
                // Payment completion outranks cancel so a simultaneous final coin still pays.
                if (paid_new >= cost_q) begin
                    state_d        = S_PAID;
                    pay_d          = 1'b1;
                    change_valid_d = 1'b1;
                    change_d       = paid_new - cost_q;
                end else if (cancel || tmo_hit) begin
                    state_d        = S_REFUND;
                    refund_d       = 1'b1;
                    change_valid_d = 1'b1;
                    change_d       = paid_new;
                end
            end
            S_PAID:   state_d = S_IDLE;
            S_REFUND: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            now_q          <= '0;
            remaining_q    <= '0;
            cost_q         <= '0;
            paid_q         <= '0;
            change_q       <= '0;
            busy_q         <= 1'b0;
            pay_q          <= 1'b0;
            refund_q       <= 1'b0;
            change_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            now_q          <= now_d;
            remaining_q    <= remaining_d;
            cost_q         <= cost_d;
            paid_q         <= paid_d;
            change_q       <= change_d;
            busy_q         <= busy_d;
            pay_q          <= pay_d;
            refund_q       <= refund_d;
            change_valid_q <= change_valid_d;
        end
    end

    assign busy         = busy_q;
    assign cost         = cost_q;
    assign pay          = pay_q;
    assign refund       = refund_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign now          = now_q;

endmodule

// File: tb/tb_pay_station.sv
// tb/tb_pay_station.sv - directed and randomized bench for pay_station with a fee-formula reference model
// Timeout checks run only when PAY_TIMEOUT_EN is defined.
module tb_pay_station;

    localparam int TW      = 16;
    localparam int TPU     = 60;
    localparam int RATE    = 2;
    localparam int MAX_FEE = 20;
    localparam int CW      = 8;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [TW-1:0] entry_time = '0;
    logic          coin_valid = 1'b0;
    logic [CW-1:0] coin_value = '0;
    logic          cancel = 1'b0;
    logic          busy;
    logic [CW-1:0] cost;
    logic          pay;
    logic          refund;
    logic          change_valid;
    logic [CW-1:0] change;
    logic [TW-1:0] now;

    pay_station #(
        .TW(TW), .TPU(TPU), .RATE(RATE), .MAX_FEE(MAX_FEE), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .entry_time(entry_time),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .busy(busy), .cost(cost), .pay(pay), .refund(refund),
        .change_valid(change_valid), .change(change), .now(now)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference tick counter: zero under reset, +1 per cycle modulo 2^TW.
    logic [TW-1:0] m_now;
    always @(posedge clk) begin
        if (rst) m_now <= '0;
        else     m_now <= m_now + 16'd1;
    end

    int exp_cost = 0;
    int exp_paid = 0;
    int exp_change = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues a request for a given elapsed time and checks the cost ramp through CALC.
    task automatic begin_txn(input int el, input bit noise);
        int units;
        int k;
        units = (el + TPU - 1) / TPU;
        if (units < 1) units = 1;
        exp_cost = imin(MAX_FEE, RATE * units);
        k = imin(units, (MAX_FEE + RATE - 1) / RATE);
        exp_paid = 0;
        req = 1'b1;
        entry_time = m_now - TW'(el);
        tick;
        check("busy_after_req", busy, 1);
        check("cost_cleared", cost, 0);
        for (int j = 1; j <= k; j++) begin
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            coin_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            coin_value = CW'($urandom_range(1, 255));
            tick;
            check("calc_cost", cost, imin(MAX_FEE, RATE * j));
        end
        req = 1'b0;
        coin_valid = 1'b0;
        check("cost_final", cost, exp_cost);
    endtask

    task automatic step(input bit cv, input int val, input bit cn, output bit done);
        bit e_pay;
        bit e_ref;
        coin_valid = cv;
        coin_value = CW'(val);
        cancel = cn;
        tick;
        coin_valid = 1'b0;
        cancel = 1'b0;
        e_pay = 1'b0;
        e_ref = 1'b0;
        if (cv) exp_paid = imin(255, exp_paid + val);
        if (exp_paid >= exp_cost) begin
            e_pay = 1'b1;
            exp_change = exp_paid - exp_cost;
        end else if (cn) begin
            e_ref = 1'b1;
            exp_change = exp_paid;
        end
        check("pay", pay, e_pay);
        check("refund", refund, e_ref);
        check("change_valid", change_valid, e_pay | e_ref);
        check("change", change, exp_change);
        check("busy_collect", busy, 1);
        done = e_pay | e_ref;
        if (done) begin
            tick;
            check("busy_done", busy, 0);
            check("pay_one_cycle", pay, 0);
            check("refund_one_cycle", refund, 0);
            check("change_valid_one_cycle", change_valid, 0);
            check("change_held", change, exp_change);
            check("cost_held", cost, exp_cost);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_change = 0;
    endtask

    initial begin
        bit done;
        int idle;
        int el;
        int r;
        int val;
        bit cn;

        // Reset state and free-running counter.
        do_reset;
        check("rst_busy", busy, 0);
        check("rst_cost", cost, 0);
        check("rst_pay", pay, 0);
        check("rst_refund", refund, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_change", change, 0);
        check("rst_now", now, 0);
        tick;
        check("now_1", now, 1);
        check("idle_busy", busy, 0);
        tick;
        check("now_2", now, 2);
        check("idle_busy", busy, 0);

        // Normal fee: elapsed 150 -> 3 units, cost 6; coins 5 + 5 -> change 4.
        begin_txn(150, 1'b0);
        check("normal_cost", cost, 6);
        step(1'b1, 5, 1'b0, done);
        check("normal_not_done", done, 0);
        step(1'b1, 5, 1'b0, done);
        check("normal_change", change, 4);

        // Cap and minimum charge.
        begin_txn(5000, 1'b0);
        check("cap_cost", cost, 20);
        step(1'b0, 0, 1'b1, done);
        begin_txn(0, 1'b0);
        check("min_cost", cost, 2);
        step(1'b1, 2, 1'b0, done);

        // Wrap-around: now = 10, entry 65530.
        do_reset;
        for (int i = 0; i < 20 && m_now != 16'd10; i++) tick;
        check("wrap_now", now, 10);
        begin_txn(16, 1'b0);
        check("wrap_cost", cost, 2);
        step(1'b1, 2, 1'b0, done);
        check("wrap_change", change, 0);

        // Cancel, then coin-and-cancel collision.
        begin_txn(150, 1'b0);
        step(1'b1, 3, 1'b0, done);
        step(1'b0, 0, 1'b1, done);
        check("cancel_change", change, 3);
        begin_txn(150, 1'b0);
        step(1'b1, 3, 1'b0, done);
        step(1'b1, 3, 1'b1, done);
        check("collision_change", change, 0);

`ifdef PAY_TIMEOUT_EN
        // Timeout: 8 coinless COLLECT cycles after the last coin.
        begin_txn(150, 1'b0);
        step(1'b1, 1, 1'b0, done);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick;
            check("tmo_no_refund_yet", refund, 0);
        end
        tick;
        check("tmo_refund", refund, 1);
        check("tmo_change", change, 1);
        check("tmo_pay", pay, 0);
        tick;
        check("tmo_busy_done", busy, 0);
`endif

        // Reset mid-collection discards everything.
        begin_txn(150, 1'b0);
        step(1'b1, 1, 1'b0, done);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_pay", pay, 0);
        check("midrst_refund", refund, 0);
        check("midrst_cost", cost, 0);
        check("midrst_change", change, 0);
        check("midrst_now", now, 0);
        exp_change = 0;
        tick;
        check("midrst_stay_idle", busy, 0);
        check("midrst_no_pay", pay, 0);
        check("midrst_no_refund", refund, 0);

        // Randomized transactions against the fee formula and coin ledger.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      el = $urandom_range(0, 59);
            else if (r == 1) el = TPU * $urandom_range(1, 12);
            else if (r == 2) el = $urandom_range(0, 1400);
            else             el = $urandom_range(0, 65535);
            begin_txn(el, 1'b1);
            check("rand_now", now, m_now);
            done = 1'b0;
            idle = 0;
            for (int s = 0; s < 30 && !done; s++) begin
                r = $urandom_range(0, 9);
                if (r < 2 && idle < 2) begin
                    step(1'b0, 0, 1'b0, done);
                    idle++;
                end else if (r == 2) begin
                    step(1'b0, 0, 1'b1, done);
                    idle = 0;
                end else begin
                    val = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(1, 5);
                    cn = ($urandom_range(0, 9) == 0);
                    step(1'b1, val, cn, done);
                    idle = 0;
                end
            end
            if (!done) step(1'b0, 0, 1'b1, done);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                coin_valid = 1'b1;
                coin_value = CW'($urandom_range(1, 255));
                tick;
                coin_valid = 1'b0;
                check("idle_busy_gap", busy, 0);
                check("idle_coin_ignored", change_valid, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
